// File: rtl/junction_lamp_ctrl.sv
// Two-road junction controller: main/side RGY lamps plus a pedestrian walk
// lamp, driven by a single saturating cycle timer and a latched ped request.
module junction_lamp_ctrl #(
   parameter int unsigned CW        = 4,
   parameter int unsigned MIN_GREEN = 8,
   parameter int unsigned YELLOW_T  = 2,
   parameter int unsigned ALLRED_T  = 1,
   parameter int unsigned SIDE_MAX  = 6,
   parameter int unsigned WALK_T    = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       side_req,
   input  logic       ped_btn,
   output logic [2:0] main_light,
   output logic [2:0] side_light,
   output logic       walk,
   output logic [2:0] state_o
);

   typedef enum logic [2:0] {
      StMainGreen  = 3'd0,
      StMainYellow = 3'd1,
      StAllRedA    = 3'd2,
      StSideGreen  = 3'd3,
      StSideYellow = 3'd4,
      StAllRedB    = 3'd5,
      StPedWalk    = 3'd6,
      StIllegal    = 3'd7
   } state_e;

   // Lamp codes: bit2=Red, bit1=Green, bit0=Yellow
   localparam logic [2:0] LAMP_R = 3'b100;
   localparam logic [2:0] LAMP_G = 3'b010;
   localparam logic [2:0] LAMP_Y = 3'b001;

   // Exit points: a phase held T cycles ends when the timer reads T-1
   localparam logic [CW-1:0] L_MIN_GREEN = CW'(MIN_GREEN - 1);
   localparam logic [CW-1:0] L_YELLOW    = CW'(YELLOW_T - 1);
   localparam logic [CW-1:0] L_ALLRED    = CW'(ALLRED_T - 1);
   localparam logic [CW-1:0] L_SIDE_MAX  = CW'(SIDE_MAX - 1);
   localparam logic [CW-1:0] L_WALK      = CW'(WALK_T - 1);
   localparam logic [CW-1:0] L_TMR_MAX   = {CW{1'b1}};

   state_e          r_state;
   state_e          w_state_d;
   logic [CW-1:0]   r_timer;
   logic            r_ped_pending;
   logic            w_ped_d;

   // Next-state selection from the current phase, timer and requests
   always_comb begin
      w_state_d = r_state;
      case (r_state)
         StMainGreen: begin
            if ((r_timer >= L_MIN_GREEN) && (side_req || r_ped_pending)) begin
               w_state_d = StMainYellow;
            end
         end
         StMainYellow: begin
            if (r_timer == L_YELLOW) w_state_d = StAllRedA;
         end
         StAllRedA: begin
            // Pedestrian wins over the side road
            if (r_timer == L_ALLRED) w_state_d = r_ped_pending ? StPedWalk : StSideGreen;
         end
         StSideGreen: begin
            if (!side_req || (r_timer == L_SIDE_MAX)) w_state_d = StSideYellow;
         end
         StSideYellow: begin
            if (r_timer == L_YELLOW) w_state_d = StAllRedB;
         end
         StPedWalk: begin
            if (r_timer == L_WALK) w_state_d = StAllRedB;
         end
         StAllRedB: begin
            if (r_timer == L_ALLRED) w_state_d = StMainGreen;
         end
         default: w_state_d = StMainGreen;
      endcase
   end

   // Pedestrian latch: cleared on entry to and during the walk phase, so a
   // press coinciding with the clear or arriving during the walk is dropped
   always_comb begin
      w_ped_d = r_ped_pending | ped_btn;
      if ((w_state_d == StPedWalk) || (r_state == StPedWalk)) w_ped_d = 1'b0;
   end

   // State, timer and request registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= StMainGreen;
         r_timer       <= '0;
         r_ped_pending <= 1'b0;
      end else begin
         r_state       <= w_state_d;
         r_ped_pending <= w_ped_d;
         if (w_state_d != r_state) begin
            r_timer <= '0;
         end else if (r_timer != L_TMR_MAX) begin
            r_timer <= r_timer + 1'b1;
         end
      end
   end

   // Moore lamp decode; anything unexpected shows all-red
   always_comb begin
      main_light = LAMP_R;
      side_light = LAMP_R;
      walk       = 1'b0;
      case (r_state)
         StMainGreen:  main_light = LAMP_G;
         StMainYellow: main_light = LAMP_Y;
         StSideGreen:  side_light = LAMP_G;
         StSideYellow: side_light = LAMP_Y;
         StPedWalk:    walk       = 1'b1;
         default: ;
      endcase
   end

   assign state_o = r_state;

endmodule

// File: tb/tb_junction_lamp_ctrl.sv
// Self-checking bench for junction_lamp_ctrl: directed scenarios plus random
// traffic, compared each cycle against a phase/elapsed-time reference model.
module tb_junction_lamp_ctrl;

   localparam int MIN_GREEN = 8;
   localparam int YELLOW_T  = 2;
   localparam int ALLRED_T  = 1;
   localparam int SIDE_MAX  = 6;
   localparam int WALK_T    = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       side_req = 1'b0;
   logic       ped_btn = 1'b0;
   logic [2:0] main_light;
   logic [2:0] side_light;
   logic       walk;
   logic [2:0] state_o;

   int n_chk = 0;
   int n_err = 0;

   // Reference model: phase number, cycles already spent in it, ped latch
   int m_phase;
   int m_elapsed;
   bit m_ped;

   always #5 clk = ~clk;

   junction_lamp_ctrl #(
      .CW        (4),
      .MIN_GREEN (MIN_GREEN),
      .YELLOW_T  (YELLOW_T),
      .ALLRED_T  (ALLRED_T),
      .SIDE_MAX  (SIDE_MAX),
      .WALK_T    (WALK_T)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .side_req   (side_req),
      .ped_btn    (ped_btn),
      .main_light (main_light),
      .side_light (side_light),
      .walk       (walk),
      .state_o    (state_o)
   );

   function automatic logic [2:0] exp_main(input int p);
      case (p)
         0:       return 3'b010;
         1:       return 3'b001;
         default: return 3'b100;
      endcase
   endfunction

   function automatic logic [2:0] exp_side(input int p);
      case (p)
         3:       return 3'b010;
         4:       return 3'b001;
         default: return 3'b100;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance the model by one clock edge given the inputs seen at that edge
   task automatic model_step(input bit sr, input bit pb, input bit r);
      int  nxt;
      bool_done: begin end
      if (r) begin
         m_phase = 0; m_elapsed = 0; m_ped = 0;
      end else begin
         nxt = m_phase;
         case (m_phase)
            0: if (m_elapsed + 1 >= MIN_GREEN && (sr || m_ped)) nxt = 1;
            1: if (m_elapsed + 1 == YELLOW_T) nxt = 2;
            2: if (m_elapsed + 1 == ALLRED_T) nxt = m_ped ? 6 : 3;
            3: if (!sr || m_elapsed + 1 == SIDE_MAX) nxt = 4;
            4: if (m_elapsed + 1 == YELLOW_T) nxt = 5;
            6: if (m_elapsed + 1 == WALK_T) nxt = 5;
            5: if (m_elapsed + 1 == ALLRED_T) nxt = 0;
            default: nxt = 0;
         endcase
         if (nxt == 6 || m_phase == 6) m_ped = 0;
         else m_ped = m_ped | pb;
         m_elapsed = (nxt != m_phase) ? 0 : m_elapsed + 1;
         m_phase = nxt;
      end
   endtask

   // Check the current cycle's outputs, then apply inputs across one edge
   task automatic cycle(input bit sr, input bit pb, input bit r);
      side_req = sr;
      ped_btn  = pb;
      rst      = r;
      chk("main_light", {5'b0, main_light}, {5'b0, exp_main(m_phase)});
      chk("side_light", {5'b0, side_light}, {5'b0, exp_side(m_phase)});
      chk("walk", {7'b0, walk}, {7'b0, (m_phase == 6)});
      chk("state_o", {5'b0, state_o}, 8'(m_phase));
      chk("ped_pending", {7'b0, dut.r_ped_pending}, {7'b0, m_ped});
      chk("safety", {7'b0, (main_light[1] & side_light[1]) |
                           (walk & ~(main_light[2] & side_light[2])) |
                           ($countones(main_light) != 1) |
                           ($countones(side_light) != 1)}, 8'h00);
      @(posedge clk);
      model_step(sr, pb, r);
      #1;
   endtask

   task automatic spot(input string tag, input int exp_state);
      chk(tag, {5'b0, state_o}, 8'(exp_state));
   endtask

   initial begin
      bit sr;
      bit pb;
      bit r;

      // Initial reset; model state is only meaningful after the first edge
      rst = 1'b1;
      @(posedge clk);
      model_step(0, 0, 1);
      #1;
      cycle(0, 0, 1);

      // Idle road: stays in main green
      for (int c = 0; c < 50; c++) cycle(0, 0, 0);
      spot("idle_state", 0);

      // Side request held high
      cycle(0, 0, 1);
      for (int c = 0; c < 32; c++) begin
         if (c == 7)  spot("s2_green_end", 0);
         if (c == 8)  spot("s2_main_yellow", 1);
         if (c == 10) spot("s2_allred_a", 2);
         if (c == 11) spot("s2_side_green", 3);
         if (c == 16) spot("s2_side_cap", 3);
         if (c == 17) spot("s2_side_yellow", 4);
         if (c == 19) spot("s2_allred_b", 5);
         if (c == 20) spot("s2_main_back", 0);
         if (c == 28) spot("s2_main_yellow2", 1);
         cycle(1, 0, 0);
      end

      // Side request drops during side green
      cycle(0, 0, 1);
      for (int c = 0; c < 20; c++) begin
         if (c == 13) spot("s3_side_green", 3);
         if (c == 14) spot("s3_side_yellow", 4);
         if (c == 16) spot("s3_allred_b", 5);
         if (c == 17) spot("s3_main_green", 0);
         cycle(c <= 12, 0, 0);
      end

      // Single pedestrian pulse
      cycle(0, 0, 1);
      for (int c = 0; c < 22; c++) begin
         if (c == 10) spot("s4_allred_a", 2);
         if (c == 11) chk("s4_walk_on", {7'b0, walk}, 8'h01);
         if (c == 14) spot("s4_walk_end", 6);
         if (c == 15) spot("s4_allred_b", 5);
         if (c == 16) spot("s4_main_green", 0);
         cycle(0, c == 2, 0);
      end

      // Pedestrian plus side traffic; extra press during walk is dropped
      cycle(0, 0, 1);
      for (int c = 0; c < 40; c++) begin
         if (c == 11) spot("s5_walk", 6);
         if (c == 16) spot("s5_main_green", 0);
         if (c == 23) spot("s5_main_hold", 0);
         if (c == 24) spot("s5_main_yellow", 1);
         if (c == 27) spot("s5_side_not_walk", 3);
         cycle(1, (c == 2) || (c == 12), 0);
      end

      // Reset in side green with a pending pedestrian request
      cycle(0, 0, 1);
      for (int c = 0; c < 30; c++) begin
         if (c == 13) chk("s6_pending_before", {7'b0, dut.r_ped_pending}, 8'h01);
         if (c == 14) spot("s6_after_reset", 0);
         if (c == 14) chk("s6_walk_off", {7'b0, walk}, 8'h00);
         if (c == 22) spot("s6_restart_yellow", 1);
         if (c == 25) spot("s6_side_green", 3);
         cycle(1, c == 12, c == 13);
      end

      // Random traffic
      sr = 0;
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(7, 0) == 0) sr = ~sr;
         pb = ($urandom_range(15, 0) == 0);
         r  = ($urandom_range(199, 0) == 0);
         cycle(sr, pb, r);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   // Absolute time bound so the run always ends
   initial begin
      #200000;
      n_err++;
      $display("FAIL timeout observed=running expected=finished");
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $fatal(1, "timeout");
   end

endmodule
